// File: rtl/vscale_mp_hasti_sram.sv
// Multi-port HASTI SRAM: NPORTS symmetric zero-wait-state slave ports over one shared word array.
// Same-cycle writes merge per byte lane (lowest port wins); illegal transfers get a two-cycle ERROR.
module vscale_mp_hasti_sram #(
  parameter int NPORTS = 2,
  parameter int NWORDS = 32
) (
  input  logic                  hclk_i,
  input  logic                  reset_i,
  input  logic [NPORTS*32-1:0]  haddr_i,
  input  logic [NPORTS-1:0]     hwrite_i,
  input  logic [NPORTS*3-1:0]   hsize_i,
  input  logic [NPORTS*3-1:0]   hburst_i,
  input  logic [NPORTS-1:0]     hmastlock_i,
  input  logic [NPORTS*4-1:0]   hprot_i,
  input  logic [NPORTS*2-1:0]   htrans_i,
  input  logic [NPORTS*32-1:0]  hwdata_i,
  output logic [NPORTS*32-1:0]  hrdata_o,
  output logic [NPORTS-1:0]     hready_o,
  output logic [NPORTS-1:0]     hresp_o
);

  localparam int WIDX = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [2:0] {IDLE_DP, RD_DP, WR_DP, ERR1, ERR2} state_e;

  logic [31:0]     mem     [NWORDS];
  logic            wr_en   [NPORTS];
  logic [WIDX-1:0] wr_idx  [NPORTS];
  logic [3:0]      wr_mask [NPORTS];

  logic unused_ok;
  assign unused_ok = ^{hburst_i, hmastlock_i, hprot_i, htrans_i};

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_port
      state_e          state_q, state_d;
      logic [WIDX-1:0] idx_q, idx_d;
      logic [1:0]      size_q, size_d;
      logic [1:0]      off_q, off_d;
      logic [31:0]     addr;
      logic [2:0]      size_in;
      logic            legal;
      logic [3:0]      lane_base;

      assign addr    = haddr_i[32*gi +: 32];
      assign size_in = hsize_i[3*gi +: 3];

      always_comb begin
        legal = (size_in <= 3'd2) && (addr[31:2] < 30'(NWORDS));
        if (size_in == 3'd1 && addr[0])
          legal = 1'b0;
        if (size_in == 3'd2 && addr[1:0] != 2'b00)
          legal = 1'b0;
      end

      // ERR1 is the only state with hready low, so every other state samples an address phase.
      always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        size_d  = size_q;
        off_d   = off_q;
        if (state_q == ERR1) begin
          state_d = ERR2;
        end else if (htrans_i[2*gi+1]) begin
          if (legal) begin
            state_d = hwrite_i[gi] ? WR_DP : RD_DP;
            idx_d   = addr[WIDX+1:2];
            size_d  = size_in[1:0];
            off_d   = addr[1:0];
          end else begin
            state_d = ERR1;
          end
        end else begin
          state_d = IDLE_DP;
        end
      end

      always_ff @(posedge hclk_i or posedge reset_i) begin
        if (reset_i) begin
          state_q <= IDLE_DP;
          idx_q   <= '0;
          size_q  <= '0;
          off_q   <= '0;
        end else begin
          state_q <= state_d;
          idx_q   <= idx_d;
          size_q  <= size_d;
          off_q   <= off_d;
        end
      end

      always_comb begin
        case (size_q)
          2'd0:    lane_base = 4'h1;
          2'd1:    lane_base = 4'h3;
          default: lane_base = 4'hF;
        endcase
      end

      assign hready_o[gi]           = (state_q != ERR1);
      assign hresp_o[gi]            = (state_q == ERR1) || (state_q == ERR2);
      assign hrdata_o[32*gi +: 32]  = (state_q == RD_DP) ? mem[idx_q] : 32'h0;
      assign wr_en[gi]              = (state_q == WR_DP);
      assign wr_idx[gi]             = idx_q;
      assign wr_mask[gi]            = lane_base << off_q;
    end
  endgenerate

  // Highest port is applied first so a lower port's later assignment wins on shared lanes.
  always_ff @(posedge hclk_i) begin
    for (int p = NPORTS - 1; p >= 0; p--) begin
      if (wr_en[p]) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_mask[p][b])
            mem[wr_idx[p]][8*b +: 8] <= hwdata_i[32*p + 8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_vscale_mp_hasti_sram.sv
// Bench for vscale_mp_hasti_sram: expected responses are queued when stimulus is driven
// and popped/compared in the data-phase cycle.
module tb_vscale_mp_hasti_sram;
  localparam int NPORTS = 2;
  localparam int NWORDS = 32;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic                 hclk = 1'b0;
  logic                 reset;
  logic [NPORTS*32-1:0] haddr, hwdata, hrdata;
  logic [NPORTS-1:0]    hwrite, hmastlock, hready, hresp;
  logic [NPORTS*3-1:0]  hsize, hburst;
  logic [NPORTS*4-1:0]  hprot;
  logic [NPORTS*2-1:0]  htrans;

  int          q_port [$];
  logic [31:0] q_data [$];
  logic [1:0]  q_rr   [$];
  string       q_name [$];

  int          total = 0;
  int          bad = 0;
  int          p;
  string       nm;
  logic [33:0] got, want;

  logic [31:0] err_addr [4] = '{32'h80, 32'h03, 32'h01, 32'h00};
  logic [2:0]  err_size [4] = '{3'd2, 3'd2, 3'd1, 3'd3};
  logic        err_wr   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int          err_port [4] = '{1, 0, 0, 1};

  vscale_mp_hasti_sram #(.NPORTS(NPORTS), .NWORDS(NWORDS)) dut (
    .hclk_i      (hclk),
    .reset_i     (reset),
    .haddr_i     (haddr),
    .hwrite_i    (hwrite),
    .hsize_i     (hsize),
    .hburst_i    (hburst),
    .hmastlock_i (hmastlock),
    .hprot_i     (hprot),
    .htrans_i    (htrans),
    .hwdata_i    (hwdata),
    .hrdata_o    (hrdata),
    .hready_o    (hready),
    .hresp_o     (hresp)
  );

  always #5 hclk = ~hclk;

  task automatic cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_addr(input int pt, input logic [1:0] tr, input logic wr,
                          input logic [2:0] sz, input logic [31:0] a);
    htrans[2*pt +: 2] = tr;
    hwrite[pt]        = wr;
    hsize[3*pt +: 3]  = sz;
    haddr[32*pt +: 32] = a;
  endtask

  task automatic expect_out(input int pt, input logic [31:0] d, input logic rdy,
                            input logic rsp, input string name);
    q_port.push_back(pt);
    q_data.push_back(d);
    q_rr.push_back({rdy, rsp});
    q_name.push_back(name);
  endtask

  task automatic do_write(input int pt, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] d);
    set_addr(pt, T_NONSEQ, 1'b1, sz, a);
    cycle();
    set_addr(pt, T_IDLE, 1'b0, 3'd0, 32'h0);
    hwdata[32*pt +: 32] = d;
    cycle();
    hwdata[32*pt +: 32] = 32'h0;
  endtask

  task automatic test_reset();
    expect_out(0, 32'h0, 1'b1, 1'b0, "reset_p0");
    expect_out(1, 32'h0, 1'b1, 1'b0, "reset_p1");
    @(negedge hclk);
    repeat (2) begin
      p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
      got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
      if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    end
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_write_read();
    set_addr(0, T_NONSEQ, 1'b1, 3'd2, 32'h08);
    cycle();
    hwdata[31:0] = 32'hDEADBEEF;
    set_addr(0, T_NONSEQ, 1'b0, 3'd2, 32'h08);
    expect_out(0, 32'hDEADBEEF, 1'b1, 1'b0, "wr_then_rd");
    cycle();
    hwdata[31:0] = 32'h0;
    set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
    got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
    if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    cycle();
  endtask

  task automatic test_byte_write();
    do_write(0, 3'd2, 32'h0C, 32'h11223344);
    do_write(0, 3'd0, 32'h0D, 32'h0000AA00);
    set_addr(1, T_NONSEQ, 1'b0, 3'd2, 32'h0C);
    expect_out(1, 32'h1122AA44, 1'b1, 1'b0, "byte_write");
    cycle();
    set_addr(1, T_IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
    got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
    if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    cycle();
  endtask

  task automatic test_concurrent_write();
    // overlapping lanes 0-1: port0 must win
    set_addr(0, T_NONSEQ, 1'b1, 3'd1, 32'h10);
    set_addr(1, T_NONSEQ, 1'b1, 3'd2, 32'h10);
    cycle();
    hwdata = {32'hFFFFFFFF, 32'h00005555};
    set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
    set_addr(1, T_IDLE, 1'b0, 3'd0, 32'h0);
    cycle();
    // disjoint lanes: port0 byte lane 3, port1 half lanes 0-1
    set_addr(0, T_NONSEQ, 1'b1, 3'd0, 32'h13);
    set_addr(1, T_NONSEQ, 1'b0, 3'd2, 32'h10);
    expect_out(1, 32'hFFFF5555, 1'b1, 1'b0, "merge_overlap");
    cycle();
    hwdata = {32'h0, 32'h77000000};
    set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
    set_addr(1, T_NONSEQ, 1'b1, 3'd1, 32'h10);
    @(negedge hclk);
    p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
    got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
    if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    cycle();
    hwdata = {32'h00009999, 32'h0};
    set_addr(1, T_IDLE, 1'b0, 3'd0, 32'h0);
    cycle();
    hwdata = '0;
    set_addr(0, T_NONSEQ, 1'b0, 3'd2, 32'h10);
    expect_out(0, 32'h77FF9999, 1'b1, 1'b0, "merge_disjoint");
    cycle();
    set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
    got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
    if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    cycle();
  endtask

  task automatic test_read_during_write();
    do_write(0, 3'd2, 32'h20, 32'h0);
    set_addr(0, T_NONSEQ, 1'b1, 3'd2, 32'h20);
    set_addr(1, T_NONSEQ, 1'b0, 3'd2, 32'h20);
    expect_out(1, 32'h0, 1'b1, 1'b0, "rd_during_wr_old");
    cycle();
    hwdata[31:0] = 32'h12345678;
    set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
    set_addr(1, T_SEQ, 1'b0, 3'd2, 32'h20);
    expect_out(1, 32'h12345678, 1'b1, 1'b0, "rd_after_wr_new");
    repeat (2) begin
      @(negedge hclk);
      p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
      got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
      if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
      cycle();
      hwdata[31:0] = 32'h0;
      set_addr(1, T_IDLE, 1'b0, 3'd0, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) set_addr(0, (i == 0) ? T_NONSEQ : T_SEQ, 1'b1, 3'd2, 32'h40 + 32'(4*i));
      else       set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
      if (i > 0) hwdata[31:0] = {8'(i - 1), 24'hC0FFEE};
      cycle();
    end
    hwdata[31:0] = 32'h0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        set_addr(1, (i == 0) ? T_NONSEQ : T_SEQ, 1'b0, 3'd2, 32'h40 + 32'(4*i));
        expect_out(1, {8'(i), 24'hC0FFEE}, 1'b1, 1'b0, "b2b_read");
      end else begin
        set_addr(1, T_IDLE, 1'b0, 3'd0, 32'h0);
      end
      if (i > 0) begin
        @(negedge hclk);
        p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
        got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
        if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
      end
      cycle();
    end
  endtask

  task automatic test_errors();
    do_write(0, 3'd2, 32'h00, 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      set_addr(err_port[i], T_NONSEQ, err_wr[i], err_size[i], err_addr[i]);
      cycle();
      set_addr(err_port[i], T_IDLE, 1'b0, 3'd0, 32'h0);
      hwdata[32*err_port[i] +: 32] = 32'hFFFFFFFF;
      expect_out(err_port[i], 32'h0, 1'b0, 1'b1, "err1");
      expect_out(err_port[i], 32'h0, 1'b1, 1'b1, "err2");
      expect_out(err_port[i], 32'h0, 1'b1, 1'b0, "err_done");
      repeat (3) begin
        @(negedge hclk);
        p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
        got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
        if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
        cycle();
      end
      hwdata = '0;
    end
    set_addr(1, T_NONSEQ, 1'b0, 3'd2, 32'h00);
    expect_out(1, 32'hCAFEF00D, 1'b1, 1'b0, "err_mem_unchanged");
    cycle();
    set_addr(1, T_IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
    got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
    if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    cycle();
  endtask

  task automatic test_boundary();
    do_write(1, 3'd2, 32'h7C, 32'h0BADF00D);
    set_addr(0, T_NONSEQ, 1'b0, 3'd2, 32'h7C);
    expect_out(0, 32'h0BADF00D, 1'b1, 1'b0, "last_word");
    cycle();
    set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
    got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
    if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    cycle();
  endtask

  task automatic test_reset_mid_write();
    do_write(0, 3'd2, 32'h04, 32'h55AA55AA);
    set_addr(0, T_NONSEQ, 1'b1, 3'd2, 32'h04);
    set_addr(1, T_NONSEQ, 1'b0, 3'd2, 32'h00);
    cycle();
    hwdata[31:0] = 32'hFFFFFFFF;
    set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
    set_addr(1, T_IDLE, 1'b0, 3'd0, 32'h0);
    expect_out(1, 32'hCAFEF00D, 1'b1, 1'b0, "pre_reset_rd");
    expect_out(0, 32'h0, 1'b1, 1'b0, "async_reset_p0");
    expect_out(1, 32'h0, 1'b1, 1'b0, "async_reset_p1");
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        reset = 1'b1;
        #1;
      end
      p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
      got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
      if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    end
    cycle();
    reset = 1'b0;
    hwdata = '0;
    set_addr(0, T_NONSEQ, 1'b0, 3'd2, 32'h04);
    expect_out(0, 32'h55AA55AA, 1'b1, 1'b0, "write_dropped");
    cycle();
    set_addr(0, T_IDLE, 1'b0, 3'd0, 32'h0);
    @(negedge hclk);
    p = q_port.pop_front(); want = {q_data.pop_front(), q_rr.pop_front()}; nm = q_name.pop_front();
    got = {hrdata[32*p +: 32], hready[p], hresp[p]}; total++;
    if (got !== want) begin bad++; $display("FAIL %s: port%0d got data=%h rdy/resp=%b want data=%h rdy/resp=%b", nm, p, got[33:2], got[1:0], want[33:2], want[1:0]); end
    cycle();
  endtask

  initial begin
    reset     = 1'b1;
    haddr     = '0;
    hwdata    = '0;
    hwrite    = '0;
    hsize     = '0;
    hburst    = '0;
    hmastlock = '0;
    hprot     = '0;
    htrans    = '0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_concurrent_write();
    test_read_during_write();
    test_back_to_back();
    test_errors();
    test_boundary();
    test_reset_mid_write();
    total++;
    if (q_port.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q_port.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vscale_mp_hasti_sram.md
Name: vscale_mp_hasti_sram

Overview:
- Parametrised multi-port HASTI SRAM. Successor to the dual-port scratchpad.
- NPORTS fully symmetric slave ports share one word array. Every port can read and write.
- Concurrent writes are merged per byte lane with fixed priority.
- Protocol violations (out-of-range or misaligned addresses) get a proper two-cycle AHB ERROR response.
- Sits on the per-core HASTI buses of the multi-core build as shared instruction/data memory.

Parameters:
- NPORTS, 2, number of HASTI slave ports (1..8).
- NWORDS, 32, depth in 32-bit words. Valid byte addresses are 0 .. 4*NWORDS-1.
- WIDX, $clog2(NWORDS), word-index width (derived, not overridden).

Ports:
- hclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- haddr  in  NPORTS*32  per-port address; port i in bits [32i+31:32i].
- hwrite  in  NPORTS  per-port write flag.
- hsize  in  NPORTS*3  per-port transfer size.
- hburst  in  NPORTS*3  ignored.
- hmastlock  in  NPORTS  ignored.
- hprot  in  NPORTS*4  ignored.
- htrans  in  NPORTS*2  per-port transfer type.
- hwdata  in  NPORTS*32  per-port write data, valid in the data phase.
- hrdata  out  NPORTS*32  per-port read data.
- hready  out  NPORTS  per-port ready.
- hresp  out  NPORTS  per-port response; 0 = OKAY, 1 = ERROR.

Behaviour:
- Reset:
  - Reset is asynchronous; every output takes its reset value immediately: hready=1, hresp=0, hrdata=0.
  - All port FSMs go to IDLE_DP and all pending data phases are discarded; a write in its data phase at reset is dropped.
  - Memory contents are not cleared.
- Address phase:
  - Sampled at a rising edge when hready[i]=1 and htrans[i] is NONSEQ or SEQ (both handled identically).
  - IDLE and BUSY are no-ops; the FSM returns to IDLE_DP.
- Legality check on a sampled transfer:
  - hsize<=2.
  - Aligned: hsize=1 requires addr[0]=0; hsize=2 requires addr[1:0]=0.
  - In range: addr[31:2] < NWORDS.
  - Illegal transfer -> ERR1. Legal transfer -> RD_DP or WR_DP, with word index, hsize and addr[1:0] latched.
- Per-port FSM states: IDLE_DP, RD_DP, WR_DP, ERR1, ERR2.
  - IDLE_DP: hready=1, hresp=0, hrdata=0.
  - RD_DP: hready=1, hresp=0, hrdata = full 32-bit word mem[latched index]. Sub-word reads return the whole word; the master selects lanes.
  - WR_DP: hready=1, hresp=0, hrdata=0. At the edge ending this cycle, the byte lanes selected by mask = ({1,3,F}[hsize] << addr[1:0]) & 4'hF are written from hwdata.
  - ERR1: hready=0, hresp=1, hrdata=0. Port inputs are ignored. Always moves to ERR2.
  - ERR2: hready=1, hresp=1, hrdata=0. The address phase is sampled normally at the end of ERR2.
  - An errored write never modifies memory.
- Latency and ordering:
  - Zero wait states for legal transfers; data phase is the cycle after the address phase.
  - A read's data phase reflects every write whose data phase ended at or before the edge that starts that read's data phase.
  - Writes in the same cycle as a read's data phase are not visible to it: read-before-write, no combinational hwdata->hrdata path.
  - Consequence: a same-port write to A followed immediately by a read of A returns the new data.
- Simultaneous writes to the same word in the same cycle:
  - Merged per byte lane.
  - Where masks overlap, the lowest-index port wins.
  - Non-overlapping lanes from all ports are all committed.
- hresp and hready are registered FSM decodes; nothing is combinational from inputs to outputs except the hrdata array read.

Test Plan:
- Reset, then port0 NONSEQ write word 0x08 = 0xDEADBEEF, size=2, followed immediately by a read of 0x08 -> port0 read data phase hrdata=0xDEADBEEF, hready=1, hresp=0.
- Port0 writes byte 0xAA to 0x0D (size=0) over an existing 0x11223344 at word 0x0C -> a read of 0x0C returns 0x1122AA44.
- Same cycle: port0 writes half 0x5555 at 0x10 and port1 writes word 0xFFFFFFFF at 0x10 -> word becomes 0xFFFF5555.
- Port1 reads 0x20 while port0 is in its write data phase for 0x20 (old value 0, new value 0x12345678) -> port1 hrdata=0; a subsequent port1 read returns 0x12345678.
- Port1 reads address 4*NWORDS (=0x80) -> ERR1 cycle (hready=0, hresp=1), then ERR2 cycle (hready=1, hresp=1), then OKAY. A misaligned write to 0x03 with size=2 gets the same two-cycle ERROR and memory is unchanged.
- Assert reset during a port0 WR_DP to 0x04 -> the write is dropped, outputs return to reset values immediately, and earlier memory contents survive.
